// File: rtl/ex_stage_alu.sv
// ex_stage_alu -- execute stage with EX/MEM pipeline register.
//
// Computes the ALU result, zero flag and branch decision for the ID/EX
// instruction. These values are registered together with the pipeline control
// bits for the MEM stage. With SHIFT_SERIAL=1, sll/srl/sra with a non-zero
// shift amount move one bit per cycle. While that happens, busy is high and
// upstream must hold its inputs.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   in_valid              ID/EX holds a valid instruction
//   alu_ctrl, funct3      ALU operation, branch condition select
//   is_branch             instruction is a conditional branch
//   op_a, op_b, rs2_data  operands and store data
//   rd_in, reg_write_in, mem_read_in, mem_write_in   pipeline controls
//   flush, mem_stall      kill EX instruction / freeze stage
//   busy                  serial shift in progress
//   out_valid, alu_result, zero, branch_taken, store_data,
//   rd_out, reg_write_out, mem_read_out, mem_write_out   EX/MEM register
module ex_stage_alu #(
  parameter int unsigned XLEN         = 32,
  parameter bit          SHIFT_SERIAL = 1'b1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic [3:0]      alu_ctrl,
  input  logic [2:0]      funct3,
  input  logic            is_branch,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [4:0]      rd_in,
  input  logic            reg_write_in,
  input  logic            mem_read_in,
  input  logic            mem_write_in,
  input  logic            flush,
  input  logic            mem_stall,
  output logic            busy,
  output logic            out_valid,
  output logic [XLEN-1:0] alu_result,
  output logic            zero,
  output logic            branch_taken,
  output logic [XLEN-1:0] store_data,
  output logic [4:0]      rd_out,
  output logic            reg_write_out,
  output logic            mem_read_out,
  output logic            mem_write_out
);

  localparam int unsigned SHW = $clog2(XLEN);

  typedef enum logic {IDLE, SHIFT} state_t;
  typedef enum logic [1:0] {SH_LL, SH_RL, SH_RA} shdir_t;

  state_t            state_q, state_d;
  logic [XLEN-1:0]   sh_val_q, sh_val_d;
  logic [SHW-1:0]    sh_cnt_q, sh_cnt_d;
  shdir_t            sh_dir_q, sh_dir_d;
  logic [4:0]        sh_rd_q, sh_rd_d;
  logic [XLEN-1:0]   sh_st_q, sh_st_d;
  logic              sh_rw_q, sh_rw_d, sh_mr_q, sh_mr_d, sh_mw_q, sh_mw_d;
  logic              sh_br_q, sh_br_d;
  logic [2:0]        sh_f3_q, sh_f3_d;

  logic              vld_q, vld_d, zero_q, zero_d, tkn_q, tkn_d;
  logic [XLEN-1:0]   res_q, res_d, st_q, st_d;
  logic [4:0]        rd_q, rd_d;
  logic              rw_q, rw_d, mr_q, mr_d, mw_q, mw_d;

  logic [SHW-1:0]    shamt;
  logic [XLEN-1:0]   alu_res, sh_next;
  logic              is_shift, accept;

  function automatic logic br_fn(input logic [2:0] f3, input logic [XLEN-1:0] r);
    case (f3)
      3'b000:         br_fn = (r == '0);
      3'b001:         br_fn = (r != '0);
      3'b100, 3'b110: br_fn = r[0];
      3'b101, 3'b111: br_fn = ~r[0];
      default:        br_fn = 1'b0;
    endcase
  endfunction

  assign shamt = op_b[SHW-1:0];
  assign busy  = (state_q == SHIFT);

  always_comb begin
    alu_res  = '0;
    is_shift = 1'b0;
    case (alu_ctrl)
      4'b0010: alu_res = op_a + op_b;
      4'b0110: alu_res = op_a - op_b;
      4'b0000: alu_res = op_a & op_b;
      4'b0001: alu_res = op_a | op_b;
      4'b0011: alu_res = op_a ^ op_b;
      4'b0100: begin alu_res = op_a << shamt; is_shift = 1'b1; end
      4'b0101: begin alu_res = op_a >> shamt; is_shift = 1'b1; end
      4'b1001: begin alu_res = $unsigned($signed(op_a) >>> shamt); is_shift = 1'b1; end
      4'b0111: alu_res = {{(XLEN-1){1'b0}}, (op_a < op_b)};
      4'b1000: alu_res = {{(XLEN-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    sh_next = sh_val_q;
    case (sh_dir_q)
      SH_LL:   sh_next = sh_val_q << 1;
      SH_RL:   sh_next = sh_val_q >> 1;
      SH_RA:   sh_next = {sh_val_q[XLEN-1], sh_val_q[XLEN-1:1]};
      default: sh_next = sh_val_q;
    endcase
  end

  assign accept = in_valid & ~busy & ~mem_stall & ~flush;

  // Priority: flush > mem_stall > shift progress > accept > bubble.
  always_comb begin
    state_d  = state_q;
    sh_val_d = sh_val_q;  sh_cnt_d = sh_cnt_q;  sh_dir_d = sh_dir_q;
    sh_rd_d  = sh_rd_q;   sh_st_d  = sh_st_q;
    sh_rw_d  = sh_rw_q;   sh_mr_d  = sh_mr_q;   sh_mw_d  = sh_mw_q;
    sh_br_d  = sh_br_q;   sh_f3_d  = sh_f3_q;
    vld_d = vld_q;  res_d = res_q;  zero_d = zero_q;  tkn_d = tkn_q;
    st_d  = st_q;   rd_d  = rd_q;   rw_d   = rw_q;    mr_d  = mr_q;  mw_d = mw_q;

    if (flush) begin
      state_d = IDLE;
      if (!mem_stall) begin
        vld_d = 1'b0; rw_d = 1'b0; mr_d = 1'b0; mw_d = 1'b0; tkn_d = 1'b0;
      end
    end else if (mem_stall) begin
      // everything holds, including the shift count
    end else if (state_q == SHIFT) begin
      sh_val_d = sh_next;
      sh_cnt_d = sh_cnt_q - SHW'(1);
      if (sh_cnt_q == SHW'(1)) begin
        state_d = IDLE;
        vld_d   = 1'b1;
        res_d   = sh_next;
        zero_d  = (sh_next == '0);
        tkn_d   = sh_br_q & br_fn(sh_f3_q, sh_next);
        st_d    = sh_st_q;  rd_d = sh_rd_q;
        rw_d    = sh_rw_q;  mr_d = sh_mr_q;  mw_d = sh_mw_q;
      end else begin
        vld_d = 1'b0; rw_d = 1'b0; mr_d = 1'b0; mw_d = 1'b0; tkn_d = 1'b0;
      end
    end else if (accept) begin
      if (SHIFT_SERIAL && is_shift && (shamt != '0)) begin
        state_d  = SHIFT;
        sh_val_d = op_a;
        sh_cnt_d = shamt;
        sh_dir_d = (alu_ctrl == 4'b0100) ? SH_LL : (alu_ctrl == 4'b0101) ? SH_RL : SH_RA;
        sh_rd_d  = rd_in;        sh_st_d = rs2_data;
        sh_rw_d  = reg_write_in; sh_mr_d = mem_read_in;  sh_mw_d = mem_write_in;
        sh_br_d  = is_branch;    sh_f3_d = funct3;
        vld_d = 1'b0; rw_d = 1'b0; mr_d = 1'b0; mw_d = 1'b0; tkn_d = 1'b0;
      end else begin
        vld_d  = 1'b1;
        res_d  = alu_res;
        zero_d = (alu_res == '0);
        tkn_d  = is_branch & br_fn(funct3, alu_res);
        st_d   = rs2_data;      rd_d = rd_in;
        rw_d   = reg_write_in;  mr_d = mem_read_in;  mw_d = mem_write_in;
      end
    end else begin
      vld_d = 1'b0; rw_d = 1'b0; mr_d = 1'b0; mw_d = 1'b0; tkn_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      sh_val_q <= '0;  sh_cnt_q <= '0;  sh_dir_q <= SH_LL;
      sh_rd_q  <= '0;  sh_st_q  <= '0;
      sh_rw_q  <= 1'b0; sh_mr_q <= 1'b0; sh_mw_q <= 1'b0;
      sh_br_q  <= 1'b0; sh_f3_q <= '0;
      vld_q <= 1'b0; res_q <= '0; zero_q <= 1'b0; tkn_q <= 1'b0;
      st_q  <= '0;   rd_q  <= '0; rw_q   <= 1'b0; mr_q  <= 1'b0; mw_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sh_val_q <= sh_val_d; sh_cnt_q <= sh_cnt_d; sh_dir_q <= sh_dir_d;
      sh_rd_q  <= sh_rd_d;  sh_st_q  <= sh_st_d;
      sh_rw_q  <= sh_rw_d;  sh_mr_q  <= sh_mr_d;  sh_mw_q <= sh_mw_d;
      sh_br_q  <= sh_br_d;  sh_f3_q  <= sh_f3_d;
      vld_q <= vld_d; res_q <= res_d; zero_q <= zero_d; tkn_q <= tkn_d;
      st_q  <= st_d;  rd_q  <= rd_d;  rw_q   <= rw_d;   mr_q  <= mr_d;  mw_q <= mw_d;
    end
  end

  assign out_valid     = vld_q;
  assign alu_result    = res_q;
  assign zero          = zero_q;
  assign branch_taken  = tkn_q;
  assign store_data    = st_q;
  assign rd_out        = rd_q;
  assign reg_write_out = rw_q;
  assign mem_read_out  = mr_q;
  assign mem_write_out = mw_q;

endmodule

// File: tb/tb_ex_stage_alu.sv
// tb_ex_stage_alu -- self-checking bench for ex_stage_alu (XLEN=32, serial shifts).
// Single-cycle operations come from a vector table. The multi-cycle shift,
// flush, stall and reset cases are hand-written sequences. Expected EX/MEM
// contents are queued when an instruction is driven. They are compared when
// out_valid shows a newly loaded instruction.
module tb_ex_stage_alu;

  logic        clk = 1'b0;
  logic        reset, in_valid, is_branch, flush, mem_stall;
  logic [3:0]  alu_ctrl;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b, rs2_data;
  logic [4:0]  rd_in;
  logic        reg_write_in, mem_read_in, mem_write_in;
  logic        busy, out_valid, zero, branch_taken;
  logic [31:0] alu_result, store_data;
  logic [4:0]  rd_out;
  logic        reg_write_out, mem_read_out, mem_write_out;

  always #5 clk = ~clk;

  ex_stage_alu #(.XLEN(32), .SHIFT_SERIAL(1'b1)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .alu_ctrl(alu_ctrl),
    .funct3(funct3), .is_branch(is_branch), .op_a(op_a), .op_b(op_b),
    .rs2_data(rs2_data), .rd_in(rd_in), .reg_write_in(reg_write_in),
    .mem_read_in(mem_read_in), .mem_write_in(mem_write_in), .flush(flush),
    .mem_stall(mem_stall), .busy(busy), .out_valid(out_valid),
    .alu_result(alu_result), .zero(zero), .branch_taken(branch_taken),
    .store_data(store_data), .rd_out(rd_out), .reg_write_out(reg_write_out),
    .mem_read_out(mem_read_out), .mem_write_out(mem_write_out)
  );

  typedef struct {
    logic [31:0] res;
    logic        zero, taken;
    logic [4:0]  rd;
    logic [31:0] st;
    logic        rw, mr, mw;
  } exp_t;

  typedef struct {
    logic [3:0]  ctrl;
    logic [31:0] a, b;
    logic        br;
    logic [2:0]  f3;
    logic [31:0] res;
    logic        taken;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[19];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b,
                       input logic br, input logic [2:0] f3, input logic [4:0] rd,
                       input logic [31:0] st, input logic rw, input logic mr, input logic mw);
    in_valid = 1'b1; alu_ctrl = c; op_a = a; op_b = b; is_branch = br; funct3 = f3;
    rd_in = rd; rs2_data = st; reg_write_in = rw; mem_read_in = mr; mem_write_in = mw;
  endtask

  task automatic push(input logic [31:0] res, input logic taken, input logic [4:0] rd,
                      input logic [31:0] st, input logic rw, input logic mr, input logic mw);
    exp_t e;
    e.res = res; e.zero = (res == 32'd0); e.taken = taken;
    e.rd = rd; e.st = st; e.rw = rw; e.mr = mr; e.mw = mw;
    sb.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // A new EX/MEM entry exists when out_valid is set after an edge that was not stalled.
  logic stall_at_edge = 1'b0;
  always @(posedge clk) stall_at_edge <= mem_stall;

  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid && !stall_at_edge) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got result %0h, expected no valid output", alu_result);
      end else begin
        e = sb.pop_front();
        chk("result", alu_result, e.res);
        chk("zero", zero, e.zero);
        chk("branch_taken", branch_taken, e.taken);
        chk("rd_out", rd_out, e.rd);
        chk("store_data", store_data, e.st);
        chk("ctrl_bits", {reg_write_out, mem_read_out, mem_write_out}, {e.rw, e.mr, e.mw});
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = '{4'b0010, 32'd5,        32'd7,        1'b0, 3'b000, 32'd12,       1'b0};
    vecs[1]  = '{4'b0110, 32'h1234,     32'h1234,     1'b1, 3'b000, 32'd0,        1'b1};
    vecs[2]  = '{4'b0110, 32'h1234,     32'h1234,     1'b1, 3'b001, 32'd0,        1'b0};
    vecs[3]  = '{4'b1000, 32'hFFFFFFFF, 32'd1,        1'b0, 3'b000, 32'd1,        1'b0};
    vecs[4]  = '{4'b0111, 32'hFFFFFFFF, 32'd1,        1'b0, 3'b000, 32'd0,        1'b0};
    vecs[5]  = '{4'b1000, 32'hFFFFFFFF, 32'd1,        1'b1, 3'b100, 32'd1,        1'b1};
    vecs[6]  = '{4'b0000, 32'hF0F0F0F0, 32'h0FF00FF0, 1'b0, 3'b000, 32'h00F000F0, 1'b0};
    vecs[7]  = '{4'b0001, 32'hF0F0F0F0, 32'h0F0F0000, 1'b0, 3'b000, 32'hFFFFF0F0, 1'b0};
    vecs[8]  = '{4'b0011, 32'hAAAAAAAA, 32'hFFFFFFFF, 1'b0, 3'b000, 32'h55555555, 1'b0};
    vecs[9]  = '{4'b1111, 32'd3,        32'd4,        1'b0, 3'b000, 32'd0,        1'b0};
    vecs[10] = '{4'b0010, 32'hFFFFFFFF, 32'd1,        1'b0, 3'b000, 32'd0,        1'b0};
    vecs[11] = '{4'b0110, 32'd0,        32'd1,        1'b0, 3'b000, 32'hFFFFFFFF, 1'b0};
    vecs[12] = '{4'b0100, 32'h12345678, 32'h20,       1'b0, 3'b000, 32'h12345678, 1'b0};
    vecs[13] = '{4'b0111, 32'd2,        32'd1,        1'b1, 3'b101, 32'd0,        1'b1};
    vecs[14] = '{4'b0110, 32'd3,        32'd3,        1'b1, 3'b010, 32'd0,        1'b0};
    vecs[15] = '{4'b0110, 32'd3,        32'd3,        1'b0, 3'b000, 32'd0,        1'b0};
    vecs[16] = '{4'b0111, 32'd1,        32'd2,        1'b1, 3'b110, 32'd1,        1'b1};
    vecs[17] = '{4'b1000, 32'd1,        32'hFFFFFFFF, 1'b0, 3'b000, 32'd0,        1'b0};
    vecs[18] = '{4'b0111, 32'd1,        32'hFFFFFFFF, 1'b1, 3'b111, 32'd1,        1'b0};

    reset = 1'b1; in_valid = 1'b0; flush = 1'b0; mem_stall = 1'b0;
    alu_ctrl = '0; funct3 = '0; is_branch = 1'b0; op_a = '0; op_b = '0;
    rs2_data = '0; rd_in = '0; reg_write_in = 1'b0; mem_read_in = 1'b0; mem_write_in = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_flags", {busy, out_valid, zero, branch_taken, reg_write_out,
                        mem_read_out, mem_write_out, rd_out}, 64'd0);
    chk("reset_data", {alu_result, store_data}, 64'd0);
    reset = 1'b0;

    // back-to-back single-cycle operations
    for (int i = 0; i < 19; i++) begin
      drive(vecs[i].ctrl, vecs[i].a, vecs[i].b, vecs[i].br, vecs[i].f3, 5'(i + 1),
            32'hC0DE0000 + 32'(i), (i % 2) == 1, (i % 4) >= 2, (i % 8) >= 4);
      push(vecs[i].res, vecs[i].taken, 5'(i + 1), 32'hC0DE0000 + 32'(i),
           (i % 2) == 1, (i % 4) >= 2, (i % 8) >= 4);
      tick();
    end
    in_valid = 1'b0;
    tick();

    // flush beats accept
    drive(4'b0010, 32'd1, 32'd2, 1'b0, 3'b000, 5'd3, 32'h1, 1'b1, 1'b0, 1'b0);
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("flush_beats_accept_valid", out_valid, 1'b0);
    tick();

    // serial sra by 4, with the next instruction held while busy
    drive(4'b1001, 32'h80000000, 32'd4, 1'b0, 3'b000, 5'd7, 32'h5555, 1'b1, 1'b0, 1'b0);
    push(32'hF8000000, 1'b0, 5'd7, 32'h5555, 1'b1, 1'b0, 1'b0);
    tick();
    drive(4'b0010, 32'd1, 32'd1, 1'b0, 3'b000, 5'd8, 32'h66, 1'b1, 1'b0, 1'b0);
    push(32'd2, 1'b0, 5'd8, 32'h66, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk($sformatf("sra_busy_%0d", k), busy, 1'b1);
      chk($sformatf("sra_no_early_valid_%0d", k), out_valid, 1'b0);
      tick();
    end
    @(negedge clk);
    chk("sra_busy_released", busy, 1'b0);
    chk("sra_valid", out_valid, 1'b1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("held_instr_valid", out_valid, 1'b1);
    tick();

    // sll by 10 flushed after the third shift edge
    drive(4'b0100, 32'd1, 32'd10, 1'b0, 3'b000, 5'd9, 32'h77, 1'b1, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    flush = 1'b1;
    @(negedge clk);
    chk("sll_busy_before_flush", busy, 1'b1);
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("flush_busy", busy, 1'b0);
    chk("flush_valid", out_valid, 1'b0);
    chk("flush_reg_write", reg_write_out, 1'b0);
    repeat (12) tick();

    // sll by 10 with a 3-cycle mem_stall mid-shift
    drive(4'b0100, 32'd1, 32'd10, 1'b0, 3'b000, 5'd10, 32'h88, 1'b1, 1'b0, 1'b1);
    push(32'h400, 1'b0, 5'd10, 32'h88, 1'b1, 1'b0, 1'b1);
    tick();
    in_valid = 1'b0;
    tick(); tick();
    mem_stall = 1'b1;
    tick(); tick(); tick();
    mem_stall = 1'b0;
    repeat (7) tick();
    @(negedge clk);
    chk("stall_shift_not_early", out_valid, 1'b0);
    chk("stall_shift_still_busy", busy, 1'b1);
    tick();
    @(negedge clk);
    chk("stall_shift_done_busy", busy, 1'b0);
    chk("stall_shift_done_valid", out_valid, 1'b1);
    tick();

    // asynchronous reset mid-shift
    drive(4'b0100, 32'd3, 32'd5, 1'b0, 3'b000, 5'd11, 32'hAB, 1'b1, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    tick(); tick();
    reset = 1'b1;
    #1;
    chk("async_reset_flags", {busy, out_valid, zero, branch_taken, reg_write_out,
                              mem_read_out, mem_write_out, rd_out}, 64'd0);
    chk("async_reset_data", {alu_result, store_data}, 64'd0);
    @(negedge clk);
    reset = 1'b0;
    drive(4'b0010, 32'd5, 32'd7, 1'b0, 3'b000, 5'd12, 32'h99, 1'b1, 1'b0, 1'b0);
    push(32'd12, 1'b0, 5'd12, 32'h99, 1'b1, 1'b0, 1'b0);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_reset_valid", out_valid, 1'b1);
    repeat (3) tick();

    chk("scoreboard_drained", 64'(sb.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
